// File: rtl/prog_mem.sv
// Program memory for the fetch stage: synchronous-read instruction store with a
// valid/ready loader write port and an optional post-reset NOP fill sweep.
module prog_mem #(
  parameter int                 DATA_W         = 15,
  parameter int                 ADDR_W         = 13,
  parameter int                 DEPTH          = 8192,
  parameter logic [DATA_W-1:0]  NOP_WORD       = {DATA_W{1'b0}},
  parameter bit                 CLEAR_ON_RESET = 1'b1
) (
  input  logic              CLK_ip,
  input  logic              RST_N_ip,
  input  logic              FETCH_EN_ip,
  input  logic [ADDR_W-1:0] ADDR_ip,
  output logic [DATA_W-1:0] DATA_op,
  output logic              DATA_VLD_op,
  input  logic              LD_VALID_ip,
  input  logic [ADDR_W-1:0] LD_ADDR_ip,
  input  logic [DATA_W-1:0] LD_DATA_ip,
  output logic              LD_READY_op,
  output logic              LD_ERR_op,
  output logic              INIT_DONE_op
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t RESET_ST = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                vld_q, vld_d;
  logic                err_q, err_d;
  logic                done_q, done_d;

  logic                ld_acc_s;
  logic                ld_in_rng_s;
  logic                rd_in_rng_s;
  logic                we_s;
  logic [IDX_W-1:0]    waddr_s;
  logic [IDX_W-1:0]    raddr_s;
  logic [DATA_W-1:0]   wdata_s;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign LD_READY_op  = (state_q == ST_RUN);
  assign ld_acc_s     = LD_VALID_ip & LD_READY_op;
  assign ld_in_rng_s  = ({1'b0, LD_ADDR_ip} < DEPTH_C);
  assign rd_in_rng_s  = ({1'b0, ADDR_ip} < DEPTH_C);
  assign raddr_s      = ADDR_ip[IDX_W-1:0];

  assign DATA_op      = data_q;
  assign DATA_VLD_op  = vld_q;
  assign LD_ERR_op    = err_q;
  assign INIT_DONE_op = done_q;

  // Next-state, sweep counter, write-port selection and write-first read path.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    we_s    = 1'b0;
    waddr_s = cnt_q[IDX_W-1:0];
    wdata_s = NOP_WORD;
    case (state_q)
      ST_CLEAR: begin
        we_s = 1'b1;
        if (cnt_q == LAST_C) begin
          state_d = ST_RUN;
          cnt_d   = {(ADDR_W+1){1'b0}};
        end else begin
          cnt_d   = cnt_q + (ADDR_W+1)'(1);
        end
      end
      ST_RUN: begin
        // Out-of-range loads are dropped rather than aliased onto a real word.
        if (ld_acc_s && ld_in_rng_s) begin
          we_s    = 1'b1;
          waddr_s = LD_ADDR_ip[IDX_W-1:0];
          wdata_s = LD_DATA_ip;
        end else if (ld_acc_s) begin
          err_d   = 1'b1;
        end else begin
          err_d   = 1'b0;
        end
        if (FETCH_EN_ip) begin
          vld_d = 1'b1;
          if (!rd_in_rng_s) begin
            data_d = NOP_WORD;
          end else if (we_s && (waddr_s == raddr_s)) begin
            data_d = wdata_s;
          end else begin
            data_d = mem[raddr_s];
          end
        end else begin
          vld_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = {(ADDR_W+1){1'b0}};
      end
    endcase
    done_d = (state_d == ST_RUN);
  end

  // Control and output registers; storage itself is never reset.
  always_ff @(posedge CLK_ip or negedge RST_N_ip) begin
    if (!RST_N_ip) begin
      state_q <= RESET_ST;
      cnt_q   <= {(ADDR_W+1){1'b0}};
      data_q  <= NOP_WORD;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Single write port into the RAM array.
  always_ff @(posedge CLK_ip) begin
    if (we_s) begin
      mem[waddr_s] <= wdata_s;
    end
  end

endmodule

// File: tb/tb_prog_mem.sv
// Scoreboard bench for prog_mem (DEPTH=16): directed sweep/reset/load cases plus
// randomized load/fetch traffic against an array-based reference model.
module tb_prog_mem;
  localparam int DW  = 15;
  localparam int AW  = 13;
  localparam int DEP = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          fetch_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic [DW-1:0] data_o;
  logic          vld_o, ready_o, err_o, done_o;

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] model [DEP];
  logic [DW-1:0] sb [$];
  logic          exp_vld = 1'b0;
  logic          exp_err = 1'b0;
  logic          mon_en = 1'b0;
  logic [DW-1:0] hold = '0;

  prog_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP)) dut (
    .CLK_ip(clk), .RST_N_ip(rst_n), .FETCH_EN_ip(fetch_en), .ADDR_ip(addr),
    .DATA_op(data_o), .DATA_VLD_op(vld_o), .LD_VALID_ip(ld_valid),
    .LD_ADDR_ip(ld_addr), .LD_DATA_ip(ld_data), .LD_READY_op(ready_o),
    .LD_ERR_op(err_o), .INIT_DONE_op(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a valid word.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("data_vld", vld_o, exp_vld);
      if (vld_o) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_data: got %0h expected none", data_o);
        end else begin
          hold = sb.pop_front();
          chk("fetch_data", data_o, hold);
        end
      end else begin
        chk("data_hold", data_o, hold);
      end
      chk("ld_err", err_o, exp_err);
      chk("ld_ready", ready_o, 1'b1);
      chk("init_done", done_o, 1'b1);
    end
  end

  // One RUN cycle: model applies the write first, then serves the read.
  task automatic cycle(input logic f, input logic [AW-1:0] fa, input logic l,
                       input logic [AW-1:0] la, input logic [DW-1:0] ld);
    fetch_en = f; addr = fa; ld_valid = l; ld_addr = la; ld_data = ld;
    @(posedge clk);
    if (l && (la < DEP)) model[la] = ld;
    if (f) sb.push_back((fa < DEP) ? model[fa] : '0);
    exp_vld = f;
    exp_err = l && (la >= DEP);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    sb.delete();
    rst_n = 1'b0;
    #1;
    chk("rst_data", data_o, 0);
    chk("rst_vld", vld_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_done", done_o, 0);
    fetch_en = 1'b1; addr = 13'd5;
    ld_valid = 1'b1; ld_addr = 13'd4; ld_data = 15'h7777;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic sweep_wait(input int expect_n);
    int n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done_o) begin
        n = i;
        break;
      end
      chk("sweep_ready", ready_o, 0);
      chk("sweep_vld", vld_o, 0);
    end
    chk("init_cycles", n, expect_n);
    for (int i = 0; i < DEP; i++) model[i] = '0;
    exp_vld = 1'b0; exp_err = 1'b0; hold = '0;
    mon_en = 1'b1;
  endtask

  initial begin
    logic          rf, rl;
    logic [AW-1:0] ra, rla;
    #3;
    do_reset();
    sweep_wait(16);
    cycle(1'b1, 13'd5, 1'b0, 13'd0, 15'h0);
    cycle(1'b0, 13'd0, 1'b1, 13'd3, 15'h2A55);
    cycle(1'b1, 13'd3, 1'b0, 13'd0, 15'h0);
    cycle(1'b1, 13'd7, 1'b1, 13'd7, 15'h1234);
    cycle(1'b1, 13'd2, 1'b1, 13'd1, 15'h0111);
    cycle(1'b0, 13'd0, 1'b1, 13'd20, 15'h5555);
    cycle(1'b1, 13'd20, 1'b0, 13'd0, 15'h0);
    cycle(1'b1, 13'd4, 1'b0, 13'd0, 15'h0);
    cycle(1'b0, 13'd0, 1'b0, 13'd0, 15'h0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 13'd0, 1'b1, AW'(i), DW'($urandom));
    for (int i = 0; i < 12; i++) cycle(1'b1, AW'(i), 1'b0, 13'd0, 15'h0);
    cycle(1'b0, 13'd0, 1'b0, 13'd0, 15'h0);
    cycle(1'b0, 13'd0, 1'b0, 13'd0, 15'h0);
    repeat (300) begin
      rf  = 1'($urandom_range(0, 1));
      rl  = 1'($urandom_range(0, 1));
      ra  = AW'($urandom_range(0, 31));
      rla = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, 31));
      cycle(rf, ra, rl, rla, DW'($urandom));
    end
    cycle(1'b0, 13'd0, 1'b1, 13'd9, 15'h4321);
    cycle(1'b1, 13'd9, 1'b0, 13'd0, 15'h0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("partial_sweep_done", done_o, 0);
    end
    do_reset();
    sweep_wait(16);
    cycle(1'b1, 13'd9, 1'b0, 13'd0, 15'h0);
    cycle(1'b1, 13'd4, 1'b0, 13'd0, 15'h0);
    cycle(1'b0, 13'd0, 1'b0, 13'd0, 15'h0);
    cycle(1'b0, 13'd0, 1'b0, 13'd0, 15'h0);
    mon_en = 1'b0;
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
